// File: rtl/ddr3_init_seq.sv
// ddr3_init_seq
// Power-up and initialisation sequencer for a DDR3 device. It steps through
// the RESET# hold, the CKE wait and tXPR. Then it loads MR2, MR3, MR1 and
// MR0, issues ZQCL, and raises init_done after tZQinit. At that point the
// bus belongs to the command scheduler.
//
// Ports
//   ck         clock; all state updates on posedge
//   rst_n      synchronous active-low reset
//   init_req   re-initialise request, honoured only once init_done is high
//   mem_rst_n  DDR3 RESET#
//   cke        DDR3 CKE
//   odt        DDR3 ODT, held low
//   cs_n, ras_n, cas_n, we_n   command bus
//   ba         bank address (mode register index during MRS)
//   addr       address / mode register value
//   init_done  high once the sequence has completed
module ddr3_init_seq #(
    parameter int                 BA_BITS   = 3,
    parameter int                 ADDR_BITS = 14,
    parameter int                 CNT_W     = 20,
    parameter int                 T_RESET   = 213220,
    parameter int                 T_CKE     = 533049,
    parameter int                 T_XPR     = 130,
    parameter int                 T_MRD     = 4,
    parameter int                 T_MOD     = 12,
    parameter int                 T_ZQINIT  = 512,
    parameter logic [ADDR_BITS-1:0] MR0     = '0,
    parameter logic [ADDR_BITS-1:0] MR1     = '0,
    parameter logic [ADDR_BITS-1:0] MR2     = '0,
    parameter logic [ADDR_BITS-1:0] MR3     = '0
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 init_req,
    output logic                 mem_rst_n,
    output logic                 cke,
    output logic                 odt,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 init_done
);

    typedef enum logic [3:0] {
        RST_HOLD,
        CKE_WAIT,
        XPR_WAIT,
        MRS2,       // MR2 issued, waiting tMRD
        MRS3,       // MR3 issued, waiting tMRD
        MRS1,       // MR1 issued, waiting tMRD
        MOD_WAIT,   // MR0 issued, waiting tMOD
        ZQ_WAIT,
        DONE
    } state_t;

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_ZQCL  = 4'b0110;

    // Counter reload values: a state lasting T cycles loads T-1 and leaves on
    // the edge where the count is already zero.
    localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE - 1);
    localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR - 1);
    localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(T_MOD - 1);
    localparam logic [CNT_W-1:0] LD_ZQ    = CNT_W'(T_ZQINIT - 1);

    // ZQCL carries A10=1 (long calibration), everything else zero.
    localparam logic [ADDR_BITS-1:0] ZQCL_ADDR = ADDR_BITS'(1024);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 mem_rst_n_nx, cke_nx, init_done_nx;
    logic [3:0]           cmd_nx;
    logic [BA_BITS-1:0]   ba_nx;
    logic [ADDR_BITS-1:0] addr_nx;
    logic                 issue_mrs, issue_zq;
    logic [BA_BITS-1:0]   mrs_ba;
    logic [ADDR_BITS-1:0] mrs_val;
    logic                 cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            // RST_HOLD starts with its own count already loaded.
            state     <= RST_HOLD;
            cnt       <= LD_RESET;
            mem_rst_n <= 1'b0;
            cke       <= 1'b0;
            odt       <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_DESEL;
            ba        <= '0;
            addr      <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mem_rst_n <= mem_rst_n_nx;
            cke       <= cke_nx;
            odt       <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= cmd_nx;
            ba        <= ba_nx;
            addr      <= addr_nx;
            init_done <= init_done_nx;
        end
    end

    // Commands are decided on the transition edge so that each one is on the
    // registered bus for exactly the first cycle of the following state.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt_zero ? cnt : cnt - CNT_W'(1);
        mem_rst_n_nx = mem_rst_n;
        cke_nx       = cke;
        init_done_nx = init_done;
        issue_mrs    = 1'b0;
        issue_zq     = 1'b0;
        mrs_ba       = '0;
        mrs_val      = '0;
        cmd_nx       = CMD_DESEL;
        ba_nx        = '0;
        addr_nx      = '0;

        case (state)
            RST_HOLD: if (cnt_zero) begin
                state_nx     = CKE_WAIT;
                cnt_nx       = LD_CKE;
                mem_rst_n_nx = 1'b1;
            end
            CKE_WAIT: if (cnt_zero) begin
                state_nx = XPR_WAIT;
                cnt_nx   = LD_XPR;
                cke_nx   = 1'b1;
            end
            XPR_WAIT: if (cnt_zero) begin
                state_nx  = MRS2;
                cnt_nx    = LD_MRD;
                issue_mrs = 1'b1;
                mrs_ba    = BA_BITS'(2);
                mrs_val   = MR2;
            end
            MRS2: if (cnt_zero) begin
                state_nx  = MRS3;
                cnt_nx    = LD_MRD;
                issue_mrs = 1'b1;
                mrs_ba    = BA_BITS'(3);
                mrs_val   = MR3;
            end
            MRS3: if (cnt_zero) begin
                state_nx  = MRS1;
                cnt_nx    = LD_MRD;
                issue_mrs = 1'b1;
                mrs_ba    = BA_BITS'(1);
                mrs_val   = MR1;
            end
            MRS1: if (cnt_zero) begin
                state_nx  = MOD_WAIT;
                cnt_nx    = LD_MOD;
                issue_mrs = 1'b1;
                mrs_ba    = BA_BITS'(0);
                mrs_val   = MR0;
            end
            MOD_WAIT: if (cnt_zero) begin
                state_nx = ZQ_WAIT;
                cnt_nx   = LD_ZQ;
                issue_zq = 1'b1;
            end
            ZQ_WAIT: if (cnt_zero) begin
                state_nx     = DONE;
                init_done_nx = 1'b1;
            end
            DONE: if (init_req) begin
                // Same effect as a reset edge: the whole sequence replays.
                state_nx     = RST_HOLD;
                cnt_nx       = LD_RESET;
                mem_rst_n_nx = 1'b0;
                cke_nx       = 1'b0;
                init_done_nx = 1'b0;
            end
            default: begin
                state_nx     = RST_HOLD;
                cnt_nx       = LD_RESET;
                mem_rst_n_nx = 1'b0;
                cke_nx       = 1'b0;
                init_done_nx = 1'b0;
            end
        endcase

        // Idle bus is DESELECT until CKE is up, NOP afterwards.
        cmd_nx = cke_nx ? CMD_NOP : CMD_DESEL;
        if (issue_mrs) begin
            cmd_nx  = CMD_MRS;
            ba_nx   = mrs_ba;
            addr_nx = mrs_val;
        end
        if (issue_zq) begin
            cmd_nx  = CMD_ZQCL;
            addr_nx = ZQCL_ADDR;
        end
    end

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Testbench for ddr3_init_seq. The reference model describes the expected
// outputs as a pure function of the number of edges since the last reset or
// honoured init_req, taken straight from the published timeline.
module tb_ddr3_init_seq;

    localparam int TR    = 10;
    localparam int TC    = 20;
    localparam int TX    = 5;
    localparam int TM    = 4;
    localparam int TMOD  = 12;
    localparam int TZ    = 8;
    localparam int E     = TR + TC + TX;          // 35
    localparam int ZQ_K  = E + 3 * TM + TMOD;     // 59
    localparam int DONE_K = ZQ_K + TZ;            // 67
    localparam logic [13:0] M0 = 14'h0520;
    localparam logic [13:0] M1 = 14'h0044;
    localparam logic [13:0] M2 = 14'h0008;
    localparam logic [13:0] M3 = 14'h0000;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic        mem_rst_n, cke, odt, cs_n, ras_n, cas_n, we_n, init_done;
    logic [2:0]  ba;
    logic [13:0] addr;

    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    logic [24:0] exp_v, act_v;

    ddr3_init_seq #(
        .BA_BITS(3), .ADDR_BITS(14), .CNT_W(20),
        .T_RESET(TR), .T_CKE(TC), .T_XPR(TX), .T_MRD(TM), .T_MOD(TMOD),
        .T_ZQINIT(TZ), .MR0(M0), .MR1(M1), .MR2(M2), .MR3(M3)
    ) dut (
        .ck(ck), .rst_n(rst_n), .init_req(init_req),
        .mem_rst_n(mem_rst_n), .cke(cke), .odt(odt),
        .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .init_done(init_done)
    );

    always #5 ck = ~ck;

    // Expected {mem_rst_n,cke,odt,cs_n,ras_n,cas_n,we_n,ba,addr,init_done}
    // kk edges after release; kk=0 is the reset image.
    function automatic logic [24:0] model(input int kk);
        logic        m_rst, m_cke, m_done;
        logic [3:0]  c;
        logic [2:0]  b;
        logic [13:0] a;
        m_rst  = (kk >= TR);
        m_cke  = (kk >= TR + TC);
        m_done = (kk >= DONE_K);
        c = m_cke ? 4'b0111 : 4'b1111;
        b = 3'd0;
        a = 14'h0;
        if (kk == E)               begin c = 4'b0000; b = 3'd2; a = M2; end
        else if (kk == E + TM)     begin c = 4'b0000; b = 3'd3; a = M3; end
        else if (kk == E + 2 * TM) begin c = 4'b0000; b = 3'd1; a = M1; end
        else if (kk == E + 3 * TM) begin c = 4'b0000; b = 3'd0; a = M0; end
        else if (kk == ZQ_K)       begin c = 4'b0110; a = 14'h0400; end
        return {m_rst, m_cke, 1'b0, c, b, a, m_done};
    endfunction

    // One clock: advance the model by what the DUT sampled, then capture.
    task automatic tick();
        @(posedge ck);
        if (!rst_n)                         k = 0;
        else if (init_req && k >= DONE_K)   k = 0;
        else                                k = k + 1;
        #1;
        exp_v = model(k);
        act_v = {mem_rst_n, cke, odt, cs_n, ras_n, cas_n, we_n, ba, addr, init_done};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_values cyc=%0d got=%h exp=%h", i, act_v, exp_v);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_sequence();
        for (int i = 0; i < 75; i++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL full_sequence k=%0d got=%h exp=%h", k, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid(input int at);
        int budget;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        budget = 0;
        while (k < at - 1 && budget < 200) begin
            tick();
            budget++;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, act_v, exp_v);
            end
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_abort at=%0d got=%h exp=%h", at, act_v, exp_v);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 75; i++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_replay k=%0d got=%h exp=%h", k, act_v, exp_v);
            end
        end
    endtask

    task automatic test_init_req();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL init_req_restart got=%h exp=%h", act_v, exp_v);
        end
        for (int i = 0; i < 75; i++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL init_req_replay k=%0d got=%h exp=%h", k, act_v, exp_v);
            end
        end
    endtask

    task automatic test_init_req_ignored();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        init_req = 1'b1;
        for (int i = 0; i < 75; i++) begin
            tick();
            if (k >= 66) init_req = 1'b0;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL init_req_ignored k=%0d got=%h exp=%h", k, act_v, exp_v);
            end
        end
        init_req = 1'b0;
    endtask

    task automatic test_reset_and_req();
        rst_n = 1'b0;
        init_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_and_req cyc=%0d got=%h exp=%h", i, act_v, exp_v);
            end
        end
        rst_n = 1'b1;
        init_req = 1'b0;
        for (int i = 0; i < 75; i++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_and_req_replay k=%0d got=%h exp=%h", k, act_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 149) != 0);
            init_req = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random k=%0d got=%h exp=%h", k, act_v, exp_v);
            end
        end
        rst_n = 1'b1;
        init_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_reset_mid(45);
        test_reset_mid(int'($urandom_range(2, 66)));
        test_init_req();
        test_init_req_ignored();
        test_reset_and_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
